// File: rtl/rtype_pkg.sv
// Shared constants for the R-type execution sequencer: instruction field
// positions, funct codes, ALU select encodings and the FSM state type.
package rtype_pkg;

    localparam int OPC_HI = 31, OPC_LO = 26;
    localparam int RS_HI  = 25, RS_LO  = 21;
    localparam int RT_HI  = 20, RT_LO  = 16;
    localparam int RD_HI  = 15, RD_LO  = 11;
    localparam int SH_HI  = 10, SH_LO  = 6;
    localparam int FN_HI  = 5,  FN_LO  = 0;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    localparam logic [4:0] ALU_SEL_ADD = 5'b00000;
    localparam logic [4:0] ALU_SEL_SUB = 5'b00001;
    localparam logic [4:0] ALU_SEL_AND = 5'b10000;
    localparam logic [4:0] ALU_SEL_OR  = 5'b10001;
    localparam logic [4:0] ALU_SEL_XOR = 5'b10010;
    localparam logic [4:0] ALU_SEL_NOR = 5'b10011;
    localparam logic [4:0] ALU_SEL_SLL = 5'b01000;
    localparam logic [4:0] ALU_SEL_SRL = 5'b01001;
    localparam logic [4:0] ALU_SEL_SRA = 5'b01010;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        ERR
    } state_t;

endpackage

// File: rtl/rtype_exec_ctrl_if.sv
// Control, register-file and ALU bus of the R-type sequencer.
// slave = sequencer side, master = the surrounding datapath/control.
interface rtype_exec_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              start;
    logic [31:0]       instr;
    logic              busy;
    logic              done;
    logic              err;
    logic              carry;
    logic [REG_AW-1:0] rf_raddr1;
    logic [REG_AW-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [4:0]        alu_sel;
    logic [DATA_W-1:0] alu_out;
    logic              alu_cout;

    modport slave (
        input  start, instr, rf_rdata1, rf_rdata2, alu_out, alu_cout,
        output busy, done, err, carry, rf_raddr1, rf_raddr2,
               rf_we, rf_waddr, rf_wdata, alu_a, alu_b, alu_sel
    );

    modport master (
        output start, instr, rf_rdata1, rf_rdata2, alu_out, alu_cout,
        input  busy, done, err, carry, rf_raddr1, rf_raddr2,
               rf_we, rf_waddr, rf_wdata, alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/rtype_decode.sv
// Combinational R-type decode: opcode/funct to ALU select and op class.
module rtype_decode
    import rtype_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [4:0] alu_sel,
    output logic       is_shift,
    output logic       is_arith,
    output logic       illegal
);
    always_comb begin
        alu_sel  = '0;
        is_shift = 1'b0;
        is_arith = 1'b0;
        illegal  = 1'b0;
        case (funct)
            FN_ADD: begin alu_sel = ALU_SEL_ADD; is_arith = 1'b1; end
            FN_SUB: begin alu_sel = ALU_SEL_SUB; is_arith = 1'b1; end
            FN_AND: alu_sel = ALU_SEL_AND;
            FN_OR:  alu_sel = ALU_SEL_OR;
            FN_XOR: alu_sel = ALU_SEL_XOR;
            FN_NOR: alu_sel = ALU_SEL_NOR;
            FN_SLL: begin alu_sel = ALU_SEL_SLL; is_shift = 1'b1; end
            FN_SRL: begin alu_sel = ALU_SEL_SRL; is_shift = 1'b1; end
            FN_SRA: begin alu_sel = ALU_SEL_SRA; is_shift = 1'b1; end
            default: illegal = 1'b1;
        endcase
        if (opcode != 6'd0) begin
            alu_sel  = '0;
            is_shift = 1'b0;
            is_arith = 1'b0;
            illegal  = 1'b1;
        end
    end
endmodule

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle R-type sequencer: read rs/rt, drive the ALU (iterating
// single-bit shifts shamt times), write rd, report done/err/carry.
module rtype_exec_ctrl
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic              clk,
    input logic              reset,
    rtype_exec_ctrl_if.slave bus
);
    state_t            state, state_nx;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] op_a, op_b, result;
    logic [4:0]        cnt;
    logic              carry_q;

    logic [4:0]        dec_sel;
    logic              is_shift, is_arith, illegal;
    logic [REG_AW-1:0] rd;
    logic [4:0]        shamt;

    assign rd    = REG_AW'(instr_q[RD_HI:RD_LO]);
    assign shamt = instr_q[SH_HI:SH_LO];

    rtype_decode u_dec (
        .opcode   (instr_q[OPC_HI:OPC_LO]),
        .funct    (instr_q[FN_HI:FN_LO]),
        .alu_sel  (dec_sel),
        .is_shift (is_shift),
        .is_arith (is_arith),
        .illegal  (illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.busy      = (state != IDLE);
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.rf_we     = 1'b0;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        bus.alu_sel   = '0;
        bus.carry     = carry_q;
        bus.alu_a     = op_a;
        bus.alu_b     = op_b;
        bus.rf_raddr1 = REG_AW'(instr_q[RS_HI:RS_LO]);
        bus.rf_raddr2 = REG_AW'(instr_q[RT_HI:RT_LO]);
        case (state)
            IDLE: if (bus.start) state_nx = READ;
            READ: state_nx = illegal ? ERR : EXEC;
            EXEC: begin
                bus.alu_sel = dec_sel;
                if (!is_shift || cnt <= 5'd1) state_nx = WB;
            end
            WB: begin
                bus.done     = 1'b1;
                bus.rf_we    = (rd != '0);
                bus.rf_waddr = rd;
                bus.rf_wdata = result;
                state_nx     = IDLE;
            end
            ERR: begin
                bus.done = 1'b1;
                bus.err  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // op_a is the ALU A register; for shifts it starts at rt and follows the
    // running result, but is not advanced on the final pass so alu_a holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            op_a    <= '0;
            op_b    <= '0;
            result  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) instr_q <= bus.instr;
                READ: if (!illegal) begin
                    op_a   <= is_shift ? bus.rf_rdata2 : bus.rf_rdata1;
                    op_b   <= bus.rf_rdata2;
                    result <= bus.rf_rdata2;
                    cnt    <= shamt;
                end
                EXEC: begin
                    if (is_shift) begin
                        // shamt=0 leaves result at rt and ignores the ALU
                        if (cnt != 5'd0) begin
                            result <= bus.alu_out;
                            cnt    <= cnt - 5'd1;
                            if (cnt > 5'd1) op_a <= bus.alu_out;
                        end
                    end else begin
                        result <= bus.alu_out;
                        if (is_arith) carry_q <= bus.alu_cout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Bench for rtype_exec_ctrl: behavioural register file and ALU around the
// DUT, results checked against an instruction-level reference model.
module tb_rtype_exec_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rtype_exec_ctrl_if #(.DATA_W(32), .REG_AW(5)) bus();

    rtype_exec_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] regs [32];
    int passed = 0;
    int total  = 0;
    bit model_carry = 1'b0;

    typedef struct { int lat; bit we; logic [4:0] waddr; logic [31:0] wdata; bit err; bit carry; } exp_t;
    typedef struct { int lat; int writes; logic [4:0] waddr; logic [31:0] wdata; bit err; bit busy_ok; int sel_cnt; } obs_t;

    // ALU environment: one-bit shifter, add/sub with carry-out, logic ops
    function automatic logic [32:0] alu_f(logic [4:0] sel, logic [31:0] a, logic [31:0] b);
        logic [32:0] r;
        r = '0;
        if (sel[4]) begin
            case (sel[1:0])
                2'd0: r = {1'b0, a & b};
                2'd1: r = {1'b0, a | b};
                2'd2: r = {1'b0, a ^ b};
                default: r = {1'b0, ~(a | b)};
            endcase
        end else if (!sel[3]) begin
            if (sel[0]) r = {1'b0, a} + {1'b0, ~b} + 33'd1;
            else        r = {1'b0, a} + {1'b0, b};
        end else begin
            case (sel[1:0])
                2'd0: r = {1'b0, a[30:0], 1'b0};
                2'd1: r = {1'b0, 1'b0, a[31:1]};
                default: r = {1'b0, a[31], a[31:1]};
            endcase
        end
        return r;
    endfunction

    assign bus.rf_rdata1 = regs[bus.rf_raddr1];
    assign bus.rf_rdata2 = regs[bus.rf_raddr2];
    assign {bus.alu_cout, bus.alu_out} = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);

    function automatic logic [31:0] mk(input int op, input int rs, input int rt,
                                       input int rd, input int sh, input int fn);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    // Instruction-level reference: architectural result, latency, carry
    function automatic exp_t model(logic [31:0] ins, bit cin);
        exp_t e;
        logic [31:0] a, b, r;
        int sh;
        a = regs[ins[25:21]];
        b = regs[ins[20:16]];
        sh = int'(ins[10:6]);
        r = '0;
        e.lat = 3; e.we = 1'b0; e.waddr = ins[15:11]; e.wdata = '0; e.err = 1'b0; e.carry = cin;
        if (ins[31:26] != 6'd0) begin
            e.err = 1'b1; e.lat = 2;
        end else begin
            case (ins[5:0])
                6'h20: begin r = a + b; e.carry = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; end
                6'h22: begin r = a - b; e.carry = (a >= b); end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h00: begin r = b << sh; e.lat = 2 + ((sh == 0) ? 1 : sh); end
                6'h02: begin r = b >> sh; e.lat = 2 + ((sh == 0) ? 1 : sh); end
                6'h03: begin r = 32'($signed(b) >>> sh); e.lat = 2 + ((sh == 0) ? 1 : sh); end
                default: begin e.err = 1'b1; e.lat = 2; end
            endcase
        end
        if (!e.err) begin
            e.we = (e.waddr != 5'd0);
            e.wdata = r;
        end
        return e;
    endfunction

    // Issue one instruction (caller is at a negedge) and observe until done.
    // poke: raise start with a different word while the DUT is busy.
    task automatic run_instr(input logic [31:0] ins, input bit poke, input logic [4:0] watch, output obs_t o);
        o.lat = -1; o.writes = 0; o.waddr = '0; o.wdata = '0; o.err = 1'b0; o.busy_ok = 1'b1; o.sel_cnt = 0;
        bus.instr = ins;
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (poke && c == 1) begin
                bus.instr = mk(0, 1, 2, 6, 0, 'h22);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy !== 1'b1) o.busy_ok = 1'b0;
            if (bus.alu_sel === watch) o.sel_cnt++;
            if (bus.rf_we === 1'b1) begin
                o.writes++;
                o.waddr = bus.rf_waddr;
                o.wdata = bus.rf_wdata;
                regs[bus.rf_waddr] = bus.rf_wdata;
            end
            if (bus.done === 1'b1) begin
                o.lat = c;
                o.err = bus.err;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.rf_we !== 1'b0)
            $display("FAIL reset_ctrl got busy=%b done=%b err=%b we=%b want all 0", bus.busy, bus.done, bus.err, bus.rf_we);
        else passed++;
        total++;
        if (bus.carry !== 1'b0 || bus.alu_sel !== 5'd0)
            $display("FAIL reset_flags got carry=%b sel=%b want 0", bus.carry, bus.alu_sel);
        else passed++;
        total++;
        if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.rf_wdata !== 32'd0 || bus.rf_waddr !== 5'd0)
            $display("FAIL reset_data got a=%h b=%h wd=%h wa=%0d want 0", bus.alu_a, bus.alu_b, bus.rf_wdata, bus.rf_waddr);
        else passed++;
    endtask

    task automatic test_add_carry();
        exp_t e; obs_t o; logic [31:0] ins;
        @(negedge clk);
        regs[1] = 32'hFFFF_FFFF; regs[2] = 32'h0000_0001;
        ins = mk(0, 1, 2, 5, 0, 'h20);
        e = model(ins, model_carry);
        run_instr(ins, 1'b0, 5'h1f, o);
        total++;
        if (o.lat !== e.lat || o.err !== e.err || !o.busy_ok)
            $display("FAIL add_timing got lat=%0d err=%b busy_ok=%b want lat=%0d err=%b busy_ok=1", o.lat, o.err, o.busy_ok, e.lat, e.err);
        else passed++;
        total++;
        if (o.writes !== 1 || o.waddr !== e.waddr || o.wdata !== e.wdata)
            $display("FAIL add_write got n=%0d rd=%0d data=%h want n=1 rd=%0d data=%h", o.writes, o.waddr, o.wdata, e.waddr, e.wdata);
        else passed++;
        total++;
        if (bus.carry !== e.carry) $display("FAIL add_carry got %b want %b", bus.carry, e.carry);
        else passed++;
        model_carry = e.carry;
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL add_done_pulse got done=%b busy=%b want 0 0", bus.done, bus.busy);
        else passed++;
    endtask

    task automatic test_sll();
        exp_t e; obs_t o; logic [31:0] ins;
        @(negedge clk);
        regs[3] = 32'h0000_0003; regs[4] = 32'h1234_5678;
        ins = mk(0, 4, 3, 7, 4, 'h00);
        e = model(ins, model_carry);
        run_instr(ins, 1'b0, 5'b01000, o);
        total++;
        if (o.lat !== e.lat || o.err !== e.err || !o.busy_ok)
            $display("FAIL sll_timing got lat=%0d err=%b busy_ok=%b want lat=%0d err=%b busy_ok=1", o.lat, o.err, o.busy_ok, e.lat, e.err);
        else passed++;
        total++;
        if (o.sel_cnt !== 4) $display("FAIL sll_exec_cycles got %0d want 4", o.sel_cnt);
        else passed++;
        total++;
        if (o.writes !== 1 || o.waddr !== e.waddr || o.wdata !== e.wdata)
            $display("FAIL sll_write got n=%0d rd=%0d data=%h want n=1 rd=%0d data=%h", o.writes, o.waddr, o.wdata, e.waddr, e.wdata);
        else passed++;
        total++;
        if (bus.carry !== model_carry) $display("FAIL sll_carry got %b want %b", bus.carry, model_carry);
        else passed++;
    endtask

    task automatic test_sra_zero();
        exp_t e; obs_t o; logic [31:0] ins;
        @(negedge clk);
        regs[8] = 32'h8000_0000;
        ins = mk(0, 1, 8, 4, 0, 'h03);
        e = model(ins, model_carry);
        run_instr(ins, 1'b0, 5'h1f, o);
        total++;
        if (o.lat !== e.lat || o.err !== e.err)
            $display("FAIL sra0_timing got lat=%0d err=%b want lat=%0d err=%b", o.lat, o.err, e.lat, e.err);
        else passed++;
        total++;
        if (o.writes !== 1 || o.waddr !== e.waddr || o.wdata !== e.wdata)
            $display("FAIL sra0_write got n=%0d rd=%0d data=%h want n=1 rd=%0d data=%h", o.writes, o.waddr, o.wdata, e.waddr, e.wdata);
        else passed++;
    endtask

    task automatic test_illegal();
        exp_t e; obs_t o;
        logic [31:0] words [2];
        words[0] = mk(0, 1, 2, 9, 0, 'h3F);
        words[1] = mk(1, 1, 2, 9, 0, 'h20);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            e = model(words[k], model_carry);
            run_instr(words[k], 1'b0, 5'h1f, o);
            total++;
            if (o.lat !== e.lat || o.err !== 1'b1)
                $display("FAIL illegal%0d_timing got lat=%0d err=%b want lat=%0d err=1", k, o.lat, o.err, e.lat);
            else passed++;
            total++;
            if (o.writes !== 0 || bus.carry !== model_carry)
                $display("FAIL illegal%0d_side got writes=%0d carry=%b want 0 %b", k, o.writes, bus.carry, model_carry);
            else passed++;
        end
    endtask

    task automatic test_rd_zero();
        exp_t e; obs_t o; logic [31:0] ins;
        @(negedge clk);
        regs[10] = 32'h0F0F_0000; regs[11] = 32'h0000_00F0;
        ins = mk(0, 10, 11, 0, 0, 'h25);
        e = model(ins, model_carry);
        run_instr(ins, 1'b0, 5'h1f, o);
        total++;
        if (o.lat !== e.lat || o.err !== 1'b0 || o.writes !== 0)
            $display("FAIL rd0 got lat=%0d err=%b writes=%0d want lat=%0d err=0 writes=0", o.lat, o.err, o.writes, e.lat);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        exp_t e; obs_t o; logic [31:0] ins; int extra;
        @(negedge clk);
        regs[1] = 32'd10; regs[2] = 32'd3;
        ins = mk(0, 1, 2, 11, 0, 'h26);
        e = model(ins, model_carry);
        run_instr(ins, 1'b1, 5'h1f, o);
        total++;
        if (o.lat !== e.lat || o.writes !== 1 || o.waddr !== e.waddr || o.wdata !== e.wdata)
            $display("FAIL busy_first got lat=%0d n=%0d rd=%0d data=%h want lat=%0d n=1 rd=%0d data=%h",
                     o.lat, o.writes, o.waddr, o.wdata, e.lat, e.waddr, e.wdata);
        else passed++;
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rf_we !== 1'b0) extra++;
        end
        total++;
        if (extra !== 0) $display("FAIL busy_not_queued got %0d active cycles want 0", extra);
        else passed++;
    endtask

    task automatic test_reset_mid_shift();
        exp_t e; obs_t o; logic [31:0] ins; int we_seen;
        @(negedge clk);
        regs[3] = 32'h0000_0001;
        bus.instr = mk(0, 0, 3, 9, 20, 'h00);
        bus.start = 1'b1;
        @(posedge clk);
        we_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.rf_we === 1'b1 || bus.done === 1'b1) we_seen++;
        end
        reset = 1'b1;
        @(negedge clk);
        if (bus.rf_we === 1'b1 || bus.done === 1'b1) we_seen++;
        total++;
        if (bus.busy !== 1'b0 || bus.alu_sel !== 5'd0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.carry !== 1'b0)
            $display("FAIL rst_mid_outputs got busy=%b sel=%b a=%h b=%h carry=%b want 0", bus.busy, bus.alu_sel, bus.alu_a, bus.alu_b, bus.carry);
        else passed++;
        total++;
        if (we_seen !== 0) $display("FAIL rst_mid_nowrite got %0d write/done cycles want 0", we_seen);
        else passed++;
        reset = 1'b0;
        model_carry = 1'b0;
        @(negedge clk);
        regs[12] = 32'h7FFF_FFFF; regs[13] = 32'h0000_0002;
        ins = mk(0, 12, 13, 14, 0, 'h20);
        e = model(ins, model_carry);
        run_instr(ins, 1'b0, 5'h1f, o);
        total++;
        if (o.lat !== e.lat || o.writes !== 1 || o.wdata !== e.wdata || bus.carry !== e.carry)
            $display("FAIL rst_mid_fresh got lat=%0d n=%0d data=%h carry=%b want lat=%0d n=1 data=%h carry=%b",
                     o.lat, o.writes, o.wdata, bus.carry, e.lat, e.wdata, e.carry);
        else passed++;
        model_carry = e.carry;
    endtask

    task automatic test_random();
        exp_t e; obs_t o; logic [31:0] ins;
        logic [5:0] fns [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h3F, 6'h21};
        int op, rs, rt;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            rs = int'($urandom_range(1, 31));
            rt = int'($urandom_range(1, 31));
            regs[rs] = $urandom;
            regs[rt] = $urandom;
            op = ($urandom_range(0, 9) == 0) ? 1 : 0;
            ins = mk(op, rs, rt, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'(fns[$urandom_range(0, 10)]));
            e = model(ins, model_carry);
            run_instr(ins, 1'b0, 5'h1f, o);
            total++;
            if (o.lat !== e.lat || o.err !== e.err || !o.busy_ok)
                $display("FAIL rand%0d_timing ins=%h got lat=%0d err=%b busy_ok=%b want lat=%0d err=%b busy_ok=1",
                         n, ins, o.lat, o.err, o.busy_ok, e.lat, e.err);
            else passed++;
            total++;
            if (o.writes !== (e.we ? 1 : 0) || (e.we && (o.waddr !== e.waddr || o.wdata !== e.wdata)))
                $display("FAIL rand%0d_write ins=%h got n=%0d rd=%0d data=%h want n=%0d rd=%0d data=%h",
                         n, ins, o.writes, o.waddr, o.wdata, e.we ? 1 : 0, e.waddr, e.wdata);
            else passed++;
            total++;
            if (bus.carry !== e.carry) $display("FAIL rand%0d_carry ins=%h got %b want %b", n, ins, bus.carry, e.carry);
            else passed++;
            model_carry = e.carry;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.instr = '0;
        repeat (2) @(posedge clk);
        test_reset();
        reset = 1'b0;
        test_add_carry();
        test_sll();
        test_sra_zero();
        test_illegal();
        test_rd_zero();
        test_busy_ignore();
        test_reset_mid_shift();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
